dds_sweep_ctrl: RTL and testbench

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl.sv | 134 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller for a DDS phase accumulator.
// Steps freq_word from f_start to f_stop by f_step, holding each value for dwell cycles.
module dds_sweep_ctrl #(
    parameter int unsigned FW_WIDTH = 32,
    parameter int unsigned DW_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                repeat_mode,
    input  logic [FW_WIDTH-1:0] f_start,
    input  logic [FW_WIDTH-1:0] f_stop,
    input  logic [FW_WIDTH-1:0] f_step,
    input  logic [DW_WIDTH-1:0] dwell,
    output logic [FW_WIDTH-1:0] freq_word,
    output logic                freq_valid,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [FW_WIDTH-1:0] freq_q, freq_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [DW_WIDTH-1:0] cnt_q, cnt_d;
    logic [FW_WIDTH-1:0] f_start_q, f_start_d;
    logic [FW_WIDTH-1:0] f_stop_q, f_stop_d;
    logic [FW_WIDTH-1:0] f_step_q, f_step_d;
    logic [DW_WIDTH-1:0] dwell_q, dwell_d;
    logic                repeat_q, repeat_d;

    logic [FW_WIDTH:0]   cand;
    logic                out_of_range;
    logic [DW_WIDTH-1:0] dwell_eff;

    // Extra carry bit catches wrap-around past the top of the word range.
    assign cand         = {1'b0, freq_q} + {1'b0, f_step_q};
    assign out_of_range = cand[FW_WIDTH] || (cand[FW_WIDTH-1:0] > f_stop_q);
    assign dwell_eff    = (dwell == '0) ? DW_WIDTH'(1) : dwell;

    always_comb begin
        state_d   = state_q;
        freq_d    = freq_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        f_start_d = f_start_q;
        f_stop_d  = f_stop_q;
        f_step_d  = f_step_q;
        dwell_d   = dwell_q;
        repeat_d  = repeat_q;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    if ((f_step == '0) || (f_start > f_stop)) begin
                        err_d = 1'b1;
                    end else begin
                        f_start_d = f_start;
                        f_stop_d  = f_stop;
                        f_step_d  = f_step;
                        dwell_d   = dwell_eff;
                        repeat_d  = repeat_mode;
                        freq_d    = f_start;
                        valid_d   = 1'b1;
                        cnt_d     = dwell_eff - DW_WIDTH'(1);
                        state_d   = StRun;
                    end
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    if (!out_of_range) begin
                        freq_d  = cand[FW_WIDTH-1:0];
                        valid_d = 1'b1;
                        cnt_d   = dwell_q - DW_WIDTH'(1);
                    end else if (repeat_q) begin
                        freq_d  = f_start_q;
                        valid_d = 1'b1;
                        cnt_d   = dwell_q - DW_WIDTH'(1);
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - DW_WIDTH'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            freq_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_step_q  <= '0;
            dwell_q   <= '0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            freq_q    <= freq_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            f_start_q <= f_start_d;
            f_stop_q  <= f_stop_d;
            f_step_q  <= f_step_d;
            dwell_q   <= dwell_d;
            repeat_q  <= repeat_d;
        end
    end

    assign freq_word  = freq_q;
    assign freq_valid = valid_q;
    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign err        = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a sweep model pushes per-cycle expectations,
// and each cycle after the clock edge the oldest one is popped and compared.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        repeat_mode;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [15:0] dwell;
    logic [31:0] freq_word;
    logic        freq_valid;
    logic        busy;
    logic        done;
    logic        err;

    dds_sweep_ctrl #(
        .FW_WIDTH(32),
        .DW_WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .repeat_mode(repeat_mode),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .freq_word  (freq_word),
        .freq_valid (freq_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] freq;
        logic        valid;
        logic        busy;
        logic        done;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_freq = 32'h0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] f, input logic v, input logic b, input logic d,
                            input logic e);
        exp_t x;
        x.freq  = f;
        x.valid = v;
        x.busy  = b;
        x.done  = d;
        x.err   = e;
        sb.push_back(x);
    endtask

    // Single sweep: at most max_run RUN cycles; if the sweep ends first, DONE then IDLE follow.
    task automatic push_sweep(input logic [31:0] fs, input logic [31:0] fsp,
                              input logic [31:0] fst, input logic [15:0] dw, input int max_run);
        logic [32:0] f;
        int          d;
        int          n;
        d = (dw == 16'd0) ? 1 : int'(dw);
        f = {1'b0, fs};
        n = 0;
        while ((f <= {1'b0, fst}) && (n < max_run)) begin
            for (int i = 0; (i < d) && (n < max_run); i++) begin
                push_exp(f[31:0], i == 0, 1'b1, 1'b0, 1'b0);
                model_freq = f[31:0];
                n++;
            end
            f = f + {1'b0, fsp};
        end
        if (n < max_run) begin
            push_exp(model_freq, 1'b0, 1'b0, 1'b1, 1'b0);
            push_exp(model_freq, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic push_repeat(input logic [31:0] fs, input logic [31:0] fsp,
                               input logic [31:0] fst, input logic [15:0] dw, input int ncyc);
        logic [32:0] f;
        int          d;
        int          n;
        d = (dw == 16'd0) ? 1 : int'(dw);
        f = {1'b0, fs};
        n = 0;
        while (n < ncyc) begin
            for (int i = 0; (i < d) && (n < ncyc); i++) begin
                push_exp(f[31:0], i == 0, 1'b1, 1'b0, 1'b0);
                model_freq = f[31:0];
                n++;
            end
            f = f + {1'b0, fsp};
            if (f > {1'b0, fst}) f = {1'b0, fs};
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("freq_word", freq_word, e.freq);
            check_val("freq_valid", {31'd0, freq_valid}, {31'd0, e.valid});
            check_val("busy", {31'd0, busy}, {31'd0, e.busy});
            check_val("done", {31'd0, done}, {31'd0, e.done});
            check_val("err", {31'd0, err}, {31'd0, e.err});
        end
    endtask

    task automatic drain();
        for (int i = 0; (i < 200) && (sb.size() > 0); i++) step();
        check_val("drain_timeout", sb.size(), 0);
    endtask

    task automatic cfg(input logic [31:0] fs, input logic [31:0] fsp, input logic [31:0] fst,
                       input logic [15:0] dw, input logic rp);
        f_start     = fs;
        f_step      = fsp;
        f_stop      = fst;
        dwell       = dw;
        repeat_mode = rp;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        cfg(32'd0, 32'd0, 32'd0, 16'd0, 1'b0);

        // Reset state
        push_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Single sweep, with a start and config changes during RUN that must be ignored
        cfg(32'd100, 32'd50, 32'd250, 16'd3, 1'b0);
        push_sweep(32'd100, 32'd50, 32'd250, 16'd3, 1000);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        cfg(32'd999, 32'd1, 32'd5000, 16'd1, 1'b1);
        step();
        start = 1'b0;
        drain();

        // Overflow: carry out must end the sweep instead of wrapping
        cfg(32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 16'd0, 1'b0);
        push_sweep(32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 16'd0, 1000);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();

        // Continuous sweep, then stop
        cfg(32'd10, 32'd10, 32'd20, 16'd1, 1'b1);
        push_repeat(32'd10, 32'd10, 32'd20, 16'd1, 8);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();
        stop = 1'b1;
        push_exp(model_freq, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        stop = 1'b0;

        // Abort at T+5, then an immediate restart is accepted
        cfg(32'd100, 32'd50, 32'd250, 16'd3, 1'b0);
        push_sweep(32'd100, 32'd50, 32'd250, 16'd3, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();
        stop = 1'b1;
        push_exp(model_freq, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        stop = 1'b0;
        push_sweep(32'd100, 32'd50, 32'd250, 16'd3, 1000);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();

        // Rejected starts
        cfg(32'd100, 32'd0, 32'd250, 16'd3, 1'b0);
        push_exp(model_freq, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp(model_freq, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();
        cfg(32'd300, 32'd50, 32'd200, 16'd3, 1'b0);
        push_exp(model_freq, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp(model_freq, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();

        // Stop beats start in IDLE: no sweep, no err
        cfg(32'd100, 32'd50, 32'd250, 16'd3, 1'b0);
        push_exp(model_freq, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        drain();

        // Reset mid-sweep at T+8
        push_sweep(32'd100, 32'd50, 32'd250, 16'd3, 8);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();
        rst = 1'b1;
        push_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        push_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
